// File: rtl/fifo_sync_if.sv
// Handshake and status bundle for the single-clock FIFO.
// The master side writes and reads; the slave side is the FIFO itself.
interface fifo_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16
);
    localparam int CNT = $clog2(MEM_DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  almost_empty;
    logic                  underflow;
    logic [CNT-1:0]        count;

    modport master (
        output wr_en, din, rd_en,
        input  full, almost_full, overflow, dout, empty, almost_empty, underflow, count
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, almost_full, overflow, dout, empty, almost_empty, underflow, count
    );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO using all MEM_DEPTH entries, with occupancy count,
// almost-full/almost-empty thresholds, error pulses and optional FWFT read.
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = MEM_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic        clk,
    input  logic        rst,
    fifo_sync_if.slave  bus
);
    localparam int ADDR = $clog2(MEM_DEPTH);
    localparam int CNT  = $clog2(MEM_DEPTH + 1);

    localparam logic [CNT-1:0]  DEPTH_C  = CNT'(MEM_DEPTH);
    localparam logic [CNT-1:0]  AF_C     = CNT'(AF_LEVEL);
    localparam logic [CNT-1:0]  AE_C     = CNT'(AE_LEVEL);
    localparam logic [ADDR-1:0] LAST_PTR = ADDR'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT-1:0]  count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic full, empty, wr_acc, rd_acc;

    // Flags are plain compares on the registered count.
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.wr_en && full;
        underflow_d = bus.rd_en && empty;

        // Explicit wrap so non-power-of-two depths use every entry.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT'(1);
            2'b01:   count_d = count_q - CNT'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only forgets it by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= bus.din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;

            // Output register doubles as the RAM read register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr_q];
                end
            end

            assign bus.dout = rd_data_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_fifo_sync.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// checks both every cycle against a queue-based model of the FIFO rules.
module tb_fifo_sync;
    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AF    = 10;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] din = '0;

    always #5 clk = ~clk;

    fifo_sync_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) if0 ();
    fifo_sync_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) if1 ();

    assign if0.wr_en = wr;
    assign if0.rd_en = rd;
    assign if0.din   = din;
    assign if1.wr_en = wr;
    assign if1.rd_en = rd;
    assign if1.din   = din;

    fifo_sync #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
        u_std (.clk(clk), .rst(rst), .bus(if0.slave));
    fifo_sync #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
        u_fwft (.clk(clk), .rst(rst), .bus(if1.slave));

    // Reference model: contents as a queue, standard dout as a held value.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout_std = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update();
        logic wr_ok, rd_ok;
        logic [DW-1:0] popped;
        if (rst) begin
            q.delete();
            exp_dout_std = '0;
            exp_ovf      = 1'b0;
            exp_unf      = 1'b0;
        end else begin
            exp_ovf = wr && (q.size() == DEPTH);
            exp_unf = rd && (q.size() == 0);
            wr_ok   = wr && (q.size() < DEPTH);
            rd_ok   = rd && (q.size() > 0);
            if (rd_ok) begin
                popped       = q.pop_front();
                exp_dout_std = popped;
            end
            if (wr_ok) q.push_back(din);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] exp_fw;
        n      = q.size();
        exp_fw = (n > 0) ? q[0] : '0;
        chk("std_count", 32'(if0.count), 32'(n));
        chk("std_empty", 32'(if0.empty), 32'(n == 0));
        chk("std_full", 32'(if0.full), 32'(n == DEPTH));
        chk("std_afull", 32'(if0.almost_full), 32'(n >= AF));
        chk("std_aempty", 32'(if0.almost_empty), 32'(n <= AE));
        chk("std_ovf", 32'(if0.overflow), 32'(exp_ovf));
        chk("std_unf", 32'(if0.underflow), 32'(exp_unf));
        chk("std_dout", 32'(if0.dout), 32'(exp_dout_std));
        chk("fw_count", 32'(if1.count), 32'(n));
        chk("fw_empty", 32'(if1.empty), 32'(n == 0));
        chk("fw_full", 32'(if1.full), 32'(n == DEPTH));
        chk("fw_afull", 32'(if1.almost_full), 32'(n >= AF));
        chk("fw_aempty", 32'(if1.almost_empty), 32'(n <= AE));
        chk("fw_ovf", 32'(if1.overflow), 32'(exp_ovf));
        chk("fw_unf", 32'(if1.underflow), 32'(exp_unf));
        chk("fw_dout", 32'(if1.dout), 32'(exp_fw));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check_all();
        $display("cyc=%0d rst=%0b wr=%0b rd=%0b din=0x%02h count=%0d dout_std=0x%02h dout_fwft=0x%02h ovf=%0b unf=%0b",
                 cyc, rst, wr, rd, din, if0.count, if0.dout, if1.dout, if0.overflow, if0.underflow);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic rdv, input logic [DW-1:0] d);
        rst = r;
        wr  = w;
        rd  = rdv;
        din = d;
        step();
    endtask

    initial begin
        // Reset
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h33);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_dout", 32'(if0.dout), 32'h0);
        chk("reset_empty", 32'(if0.empty), 32'h1);

        // Fill 0x01..0x0C, then an extra write overflows
        for (int i = 1; i <= DEPTH; i++) drive(1'b0, 1'b1, 1'b0, 8'(i));
        chk("filled_full", 32'(if0.full), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 8'h0D);
        chk("ovf13", 32'(if0.overflow), 32'h1);
        chk("ovf13_count", 32'(if0.count), 32'd12);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_pulse_end", 32'(if0.overflow), 32'h0);

        // Drain 12, then an extra read underflows and dout holds
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_dout", 32'(if0.dout), 32'(i));
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf13", 32'(if0.underflow), 32'h1);
        chk("unf13_hold", 32'(if0.dout), 32'h0C);

        // Refill to 5 (pointers have wrapped), then 20 cycles of simultaneous wr/rd
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b1, 8'($urandom));
        chk("simul_count", 32'(if0.count), 32'd5);

        // Drain to empty, then simultaneous write/read on empty
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'hAA);
        chk("empty_simul_unf", 32'(if0.underflow), 32'h1);
        chk("empty_simul_count", 32'(if0.count), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("aa_readback", 32'(if0.dout), 32'hAA);

        // FWFT behaviour
        drive(1'b0, 1'b1, 1'b0, 8'h55);
        chk("fw_show55", 32'(if1.dout), 32'h55);
        chk("fw_notempty", 32'(if1.empty), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fw_zero", 32'(if1.dout), 32'h0);
        chk("fw_empty_again", 32'(if1.empty), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 8'h11);
        drive(1'b0, 1'b1, 1'b0, 8'h22);
        chk("fw_show11", 32'(if1.dout), 32'h11);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fw_show22", 32'(if1.dout), 32'h22);

        // Fill to 7, then reset together with a write
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
        chk("seven", 32'(if0.count), 32'd7);
        drive(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("rst_count", 32'(if0.count), 32'd0);
        chk("rst_ovf", 32'(if0.overflow), 32'h0);
        chk("rst_fw_dout", 32'(if1.dout), 32'h0);

        // Random traffic, write-heavy then read-heavy, with rare resets
        for (int i = 0; i < 400; i++) begin
            logic w, r, s;
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            s = ($urandom_range(0, 79) == 0);
            drive(s, w, r, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
